// File: rtl/sdm_pkg.sv
// Shared constants and arithmetic helpers for the multi-channel sigma-delta modulator.
package sdm_pkg;

  localparam int ORDER_1 = 1;
  localparam int ORDER_2 = 2;

  // Wide scratch type so saturate() serves any integrator width up to 64 bits.
  localparam int WIDE_W = 64;
  typedef logic signed [WIDE_W-1:0] wide_t;

  function automatic int integ_w(input int data_w);
    return data_w + 3;
  endfunction

  // Clamp v into the signed range of a w-bit register.
  function automatic wide_t saturate(input wide_t v, input int w);
    wide_t hi;
    wide_t lo;
    hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo = -(wide_t'(1) <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/sdm_channel.sv
// One modulator channel: hold register, first/second-order saturating integrators
// and the registered 1-bit output.
module sdm_channel
  import sdm_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ORDER  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tick,
  input  logic                     load,
  input  logic signed [DATA_W-1:0] din,
  output logic                     dout
);

  localparam int    IW = integ_w(DATA_W);
  localparam wide_t FS = wide_t'(1) <<< (DATA_W - 1);

  logic signed [DATA_W-1:0] hold_q, hold_d, x;
  logic signed [IW-1:0]     i1_q, i1_d, i2_q, i2_d;
  logic                     dout_q, dout_d, bit_now;
  wide_t                    fb;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    hold_d = hold_q;
    i1_d   = i1_q;
    i2_d   = i2_q;
    dout_d = dout_q;
    // A vector loaded on this tick is already the one being modulated.
    x       = load ? din : hold_q;
    bit_now = (ORDER == ORDER_2) ? ~i2_q[IW-1] : ~i1_q[IW-1];
    fb      = bit_now ? FS : -FS;
    if (load) hold_d = din;
    if (tick) begin
      dout_d = bit_now;
      i1_d   = IW'(saturate(wide_t'(i1_q) + wide_t'(x) - fb, IW));
      if (ORDER == ORDER_2)
        i2_d = IW'(saturate(wide_t'(i2_q) + wide_t'(i1_q) - fb, IW));
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      hold_q <= '0;
      i1_q   <= '0;
      i2_q   <= '0;
      dout_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      i1_q   <= i1_d;
      i2_q   <= i2_d;
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/sdm_multi_mod.sv
// Multi-channel sigma-delta modulator: shared prescaler and single-slot input
// handshake feeding CHANNELS independent sdm_channel instances.
module sdm_multi_mod
  import sdm_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int CHANNELS = 2,
  parameter int ORDER    = 1,
  parameter int DIV      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [CHANNELS*DATA_W-1:0] s_data,
  output logic                       tick,
  output logic [CHANNELS-1:0]        dout
);

  if (!(ORDER == ORDER_1 || ORDER == ORDER_2) || DIV < 1) begin : g_bad_param
    $error("sdm_multi_mod: ORDER must be 1 or 2 and DIV must be >= 1");
  end

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0]              cnt_q, cnt_d;
  logic                       tick_q, tick_d;
  logic                       pend_q, pend_d;
  logic [CHANNELS*DATA_W-1:0] pend_data_q, pend_data_d;
  logic                       load;

  always_comb begin
    cnt_d       = (cnt_q == CW'(DIV - 1)) ? '0 : cnt_q + 1'b1;
    // tick is registered so it is high exactly while the count sits at DIV-1.
    tick_d      = (cnt_d == CW'(DIV - 1));
    load        = tick_q & pend_q;
    pend_d      = pend_q;
    pend_data_d = pend_data_q;
    if (load) pend_d = 1'b0;
    // A transfer needs pend_q clear, so it can never collide with a load.
    if (s_valid && !pend_q) begin
      pend_d      = 1'b1;
      pend_data_d = s_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      tick_q      <= 1'b0;
      pend_q      <= 1'b0;
      pend_data_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      tick_q      <= tick_d;
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
    end
  end

  assign s_ready = ~pend_q;
  assign tick    = tick_q;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    sdm_channel #(
      .DATA_W(DATA_W),
      .ORDER (ORDER)
    ) u_ch (
      .clk (clk),
      .rst (rst),
      .tick(tick_q),
      .load(load),
      .din (pend_data_q[k*DATA_W +: DATA_W]),
      .dout(dout[k])
    );
  end

endmodule

// File: tb/tb_sdm_multi_mod.sv
// Directed bench: three instances (order 1 / div 1, order 2 / div 1, order 1 / div 4).
module tb_sdm_multi_mod;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a = 1'b1, sv_a = 1'b0, rdy_a, tick_a;
  logic        rst_b = 1'b1, sv_b = 1'b0, rdy_b, tick_b;
  logic        rst_c = 1'b1, sv_c = 1'b0, rdy_c, tick_c;
  logic [31:0] sd_a = '0, sd_b = '0, sd_c = '0;
  logic [1:0]  dout_a, dout_b, dout_c;

  int total = 0;
  int bad   = 0;

  sdm_multi_mod #(.DATA_W(16), .CHANNELS(2), .ORDER(1), .DIV(1)) dut_a (
    .clk(clk), .rst(rst_a), .s_valid(sv_a), .s_ready(rdy_a),
    .s_data(sd_a), .tick(tick_a), .dout(dout_a)
  );

  sdm_multi_mod #(.DATA_W(16), .CHANNELS(2), .ORDER(2), .DIV(1)) dut_b (
    .clk(clk), .rst(rst_b), .s_valid(sv_b), .s_ready(rdy_b),
    .s_data(sd_b), .tick(tick_b), .dout(dout_b)
  );

  sdm_multi_mod #(.DATA_W(16), .CHANNELS(2), .ORDER(1), .DIV(4)) dut_c (
    .clk(clk), .rst(rst_c), .s_valid(sv_c), .s_ready(rdy_c),
    .s_data(sd_c), .tick(tick_c), .dout(dout_c)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int          ones0, ones1, cyc, pend_m;
  logic [7:0]  pat0, pat1;
  logic        xfer, prev_tick;

  initial begin
    // ---- A: order 1, div 1, ch0 = +FS/2, ch1 = 0
    step(); step();
    check("a_rst_dout", dout_a, 2'b00);
    check("a_rst_tick", tick_a, 1'b0);
    check("a_rst_rdy", rdy_a, 1'b1);
    rst_a = 1'b0;
    sv_a  = 1'b1;
    sd_a  = {16'h0000, 16'h4000};
    step();
    check("a_pend_rdy", rdy_a, 1'b0);
    check("a_tick1", tick_a, 1'b1);
    sv_a = 1'b0;
    step();
    check("a_rdy_back", rdy_a, 1'b1);
    ones0 = 0; ones1 = 0; pat0 = '0; pat1 = '0;
    for (int i = 0; i < 64; i++) begin
      if (i > 0) step();
      ones0 += int'(dout_a[0]);
      ones1 += int'(dout_a[1]);
      if (i < 8) begin
        pat0[i] = dout_a[0];
        pat1[i] = dout_a[1];
      end
    end
    check("a_pat_ch0", pat0, 8'hDD);
    check("a_pat_ch1", pat1, 8'h55);
    check("a_ones_ch0", ones0, 48);
    check("a_ones_ch1", ones1, 32);

    // ---- B: order 2, div 1, ch0 = +FS/2, ch1 = -FS/2
    step();
    rst_b = 1'b0;
    sv_b  = 1'b1;
    sd_b  = {16'hC000, 16'h4000};
    step();
    sv_b = 1'b0;
    step();
    ones0 = 0; ones1 = 0;
    for (int i = 0; i < 1024; i++) begin
      if (i > 0) step();
      ones0 += int'(dout_b[0]);
      ones1 += int'(dout_b[1]);
    end
    check("b_ones_ch0_in_range", (ones0 >= 766 && ones0 <= 770), 1'b1);
    check("b_ones_ch1_in_range", (ones1 >= 254 && ones1 <= 258), 1'b1);

    // ---- C: order 1, div 4, continuous valid with changing data
    check("c_rst_tick", tick_c, 1'b0);
    check("c_rst_rdy", rdy_c, 1'b1);
    rst_c  = 1'b0;
    sv_c   = 1'b1;
    cyc    = 0;
    pend_m = 0;
    for (int c = 0; c < 22; c++) begin
      sd_c      = {16'(c * 3), 16'(c * 5 + 1)};
      xfer      = (pend_m == 0);
      prev_tick = (cyc % 4 == 3);
      step();
      cyc++;
      if (prev_tick && pend_m == 1) pend_m = 0;
      if (xfer) pend_m = 1;
      check("c_tick", tick_c, (cyc % 4 == 3));
      check("c_rdy", rdy_c, (pend_m == 0));
    end

    // Mid-operation reset with a vector pending; valid stays high during reset.
    check("c_pending_before_rst", rdy_c, 1'b0);
    rst_c = 1'b1;
    step();
    check("c_rst2_dout", dout_c, 2'b00);
    check("c_rst2_tick", tick_c, 1'b0);
    check("c_rst2_rdy", rdy_c, 1'b1);
    rst_c = 1'b0;
    sv_c  = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      check("c_rel_tick", tick_c, (k == 3));
      check("c_rel_rdy", rdy_c, 1'b1);
      if (k < 4) check("c_rel_dout_quiet", dout_c, 2'b00);
      else       check("c_rel_dout_first", dout_c, 2'b11);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
